core_dg_sink: RTL
=================

# core_dg_sink

Synchronous receiving end of the core data-generator channel. It accepts 11-bit flits from a four-phase bundled-data handshake (req/ack), synchronizes the request into the local clock domain, and splits each flit into a 3-bit source ID and an 8-bit payload. It checks each payload against a per-source expected sequence and forwards accepted payloads through a 2-entry output buffer with a valid/ready interface. It terminates a NoC port in the synchronous test/host domain and mirrors the behaviour of the cosim checker in hardware.

## Interface
Parameters:
- W, 11, flit width; must equal SRC_W + DATA_W
- SRC_W, 3, source-ID field width, flit bits [W-1:DATA_W]
- DATA_W, 8, payload field width, flit bits [DATA_W-1:0]
- SYNC_STAGES, 2, flops in the in_req synchronizer (minimum 2)
- CNT_W, 16, width of the ok/error counters

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- _RESET  in  1  synchronous, active-low reset, sampled on the CLK rising edge
- in_req  in  1  four-phase request, asynchronous to CLK
- in_data  in  W  bundled data; stable from in_req rise until in_ack rise
- in_ack  out  1  four-phase acknowledge, registered
- out_valid  out  1  output buffer non-empty
- out_ready  in  1  consumer accepts the head entry when out_valid & out_ready
- out_src  out  SRC_W  source ID of the head entry
- out_data  out  DATA_W  payload of the head entry
- out_err  out  1  head entry failed the sequence check
- ok_cnt  out  CNT_W  count of in-sequence flits, saturating
- err_cnt  out  CNT_W  count of out-of-sequence flits, saturating

## Operation
- Synchronizer: in_req passes through SYNC_STAGES flops to form req_s. Logic uses only req_s.
- FSM states:
  - IDLE: in_ack=0. If req_s=1 and buffer count<2, go to CAPTURE. If the buffer is full, stay in IDLE; this is the backpressure mechanism, and in_ack stays low.
  - CAPTURE: one cycle. Latch in_data, perform the check, push into the buffer. Go to ACK_HI.
  - ACK_HI: in_ack=1. Stay until req_s=0, then go to IDLE. in_ack drops on the transition edge.
- Sequence check:
  - exp[0..2^SRC_W-1] is an array of DATA_W-bit registers; reset value of each entry is 1.
  - Match when payload == exp[src]: ok_cnt+1, out_err=0 for that entry.
  - Mismatch: err_cnt+1, out_err=1 for that entry.
  - In both cases exp[src] ← payload+1 modulo 2^DATA_W (255 → 0), so the checker resyncs after an error.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Output buffer:
  - 2-entry FIFO of {src, data, err}; the head drives out_*.
  - Pop on out_valid & out_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push is accepted only when count<2 is evaluated in the IDLE→CAPTURE decision, so overflow is impossible.
- Reset values:
  - in_ack=0, out_valid=0, out_src=0, out_data=0, out_err=0, ok_cnt=0, err_cnt=0
  - FSM=IDLE, buffer empty, synchronizer flops 0, all exp entries =1
- Reset mid-handshake: all state returns to the reset values and in_ack drops the next edge. If in_req is still high after _RESET deasserts, it is treated as a new transfer and captured again; upstream must be reset together with this block.

## Timing
- in_req rise to in_ack rise: SYNC_STAGES+2 cycles with the buffer not full (sync, IDLE decision, CAPTURE, ack registered).
- in_req fall to in_ack fall: SYNC_STAGES+1 cycles.
- Capture to out_valid: out_valid is high the cycle after CAPTURE (registered push).
- Counters update in the cycle after CAPTURE.
- Throughput: at most one flit per 2·SYNC_STAGES+3 cycles, limited by the handshake.
- out_* fields are stable while out_valid=1 and out_ready=0.

## Test plan
- Reset: hold _RESET=0 for 5 cycles with in_req=1 → in_ack=0, out_valid=0, counters 0. Release → exactly one capture of the presented flit.
- In-order stream: source 0 sends payloads 1..10 (flits 0x001..0x00A), out_ready=1 → 10 entries, all out_err=0, ok_cnt=10, err_cnt=0. Measure req→ack = 4 cycles at SYNC_STAGES=2.
- Gap and resync: source 2 sends 1,2,5,6 → entries 3 and 4 carry out_err=1 and 0 respectively; err_cnt=1, ok_cnt=3.
- Wrap-around: source 7 sends 1..255 then 0 → no errors; exp[7] wraps to 0 and the payload 0 flit is accepted as ok.
- Backpressure: out_ready=0 and three flits offered → two buffered, third handshake stalls with in_ack=0. Then out_ready=1 for one cycle → third flit is captured, and its ack follows within SYNC_STAGES+2 cycles.
- Saturation/interleave: force ok_cnt near 0xFFFF using interleaved sources 0 and 1 → counter holds at 0xFFFF, and per-source expected values stay independent.

Source files
------------

// File: rtl/core_dg_sink.sv
// Receiving end of the core data-generator channel: four-phase req/ack capture,
// per-source sequence checking, and a 2-entry valid/ready output buffer.
module core_dg_sink #(
  parameter int W           = 11,
  parameter int SRC_W       = 3,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              _RESET,
  input  logic              in_req,
  input  logic [W-1:0]      in_data,
  output logic              in_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SRC_W-1:0]  out_src,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int NSRC = 2 ** SRC_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK_HI  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
    logic              err;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Request synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  // NOTE: sequential state is written with <= so every flop samples the values
  // from before the edge; blocking assignments here would collapse the chain.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [1:0] count_q;
  logic       capture;

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_s && (count_q != 2'd2)) state_d = CAPTURE;
      CAPTURE: state_d = ACK_HI;
      ACK_HI:  if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign capture = (state_q == CAPTURE);

  // Ack is registered from the next state so it rises as CAPTURE completes and
  // falls on the same edge that returns to IDLE.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      state_q <= IDLE;
      in_ack  <= 1'b0;
    end else begin
      state_q <= state_d;
      in_ack  <= (state_d == ACK_HI);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequence checker and saturating counters
  // ---------------------------------------------------------------------------
  logic [SRC_W-1:0]  src_in;
  logic [DATA_W-1:0] pay_in;
  logic [DATA_W-1:0] exp_q [NSRC];
  logic              match;

  assign src_in = in_data[W-1:DATA_W];
  assign pay_in = in_data[DATA_W-1:0];
  assign match  = (pay_in == exp_q[src_in]);

  // The expected value follows the received payload on both outcomes, so a
  // single gap costs exactly one error before the checker resynchronizes.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      for (int i = 0; i < NSRC; i++) exp_q[i] <= DATA_W'(1);
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (capture) begin
      exp_q[src_in] <= pay_in + 1'b1;
      if (match) begin
        if (ok_cnt != '1) ok_cnt <= ok_cnt + 1'b1;
      end else begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry output buffer
  // ---------------------------------------------------------------------------
  entry_t mem_q [2];
  logic   wr_ptr_q, rd_ptr_q;
  logic   push, pop;
  entry_t head;

  assign push = capture;
  assign pop  = out_valid & out_ready;

  // NOTE: the two storage entries are reset because the head drives out_* and
  // those outputs have defined reset values; larger buffers would skip this.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{src: src_in, data: pay_in, err: ~match};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != 2'd0);
  assign out_src   = head.src;
  assign out_data  = head.data;
  assign out_err   = head.err;

endmodule
